seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
- Parametrised magnitude comparator that compares two WIDTH-bit operands MSB-first, DIGIT bits per clock.
- Stops early at the first differing digit.
- Returns the team's 3-bit one-hot compare code behind a start/busy/done handshake.
- Supports unsigned and two's-complement modes. Used where wide compares must not sit in one combinational path.

Parameters:
- WIDTH, 16, operand width in bits (>=1).
- DIGIT, 4, bits compared per cycle; WIDTH % DIGIT must be 0, otherwise elaboration error; NCHUNK = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request compare; accepted only when busy=0
- in1  input  WIDTH  operand A, sampled on accepted start
- in2  input  WIDTH  operand B, sampled on accepted start
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on accepted start
- busy  output  1  high from the cycle after accept until done clears
- done  output  1  one-cycle pulse, result valid
- out  output  3  result code: 3'b100 in1<in2, 3'b010 equal, 3'b001 in1>in2; 3'b000 = no result since reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it overrides all other inputs on the edge where it is high.
- Reset values: state=IDLE, busy=0, done=0, out=3'b000, chunk index=NCHUNK-1, operand registers cleared.
- State IDLE:
  - busy=0.
  - start=1 → latch in1, in2, signed_mode; index=NCHUNK-1; next state CMP.
  - start=0 → stay.
- State CMP (busy=1), one chunk per cycle, chunk = bits [idx*DIGIT+DIGIT-1 : idx*DIGIT]:
  - Signed mode: on the top chunk only, the MSB of both operands is inverted before the compare (offset-binary), so negative < positive.
  - Chunks differ → record 3'b100 or 3'b001; next state DONE.
  - Chunks equal and idx==0 → record 3'b010; next state DONE.
  - Chunks equal and idx>0 → idx-1; stay in CMP.
- State DONE (busy=1 for this cycle):
  - done=1 and out shows the recorded result.
  - Next state IDLE unconditionally.
- Output holding: out changes only on the edge entering DONE (or on reset). It holds the last result indefinitely, including through later busy periods, until the next DONE.
- Latency (accept edge = cycle 0):
  - First CMP cycle = 1.
  - done asserted at cycle k+1, where k = chunks examined (1..NCHUNK).
  - Minimum 2 cycles; maximum NCHUNK+1 cycles (equal operands or difference only in the lowest chunk).
- Throughput: start is accepted the cycle after done (IDLE). Back-to-back requests therefore take one idle cycle each.
- Ignored inputs:
  - start while busy=1 is ignored, not queued.
  - Changes on in1/in2/signed_mode after accept have no effect.
- Reset mid-operation: abandons the compare. busy, done and out return to reset values on that edge; no done pulse is produced.
- Degenerate configs:
  - DIGIT=WIDTH → single CMP cycle, fixed 2-cycle latency.
  - WIDTH=1, DIGIT=1, unsigned → truth table: 0/1→100, 1/0→001, equal→010.
  - WIDTH=1 signed: 1 (= -1) < 0.

Test Plan:
1. Defaults, unsigned, in1=16'h1234, in2=16'h1235, start at cycle 0 → busy cycles 1–5; done=1 only at cycle 5; out=3'b100 from cycle 5.
2. in1=16'h8000, in2=16'h7FFF: unsigned → out=3'b001 with done at cycle 2; signed_mode=1 → out=3'b100 with done at cycle 2.
3. in1=in2=16'hABCD, both modes → out=3'b010, done at cycle 5; out holds 3'b010 through 10 further idle cycles.
4. Accept 16'h0001 vs 16'h0002, then pulse start with 16'hFFFF vs 16'h0000 at cycle 2 → second request ignored; out=3'b100 at cycle 5. A new start at cycle 6 is accepted, giving done at cycle 8 with out=3'b001.
5. Assert rst at cycle 3 of an equal-operand compare → at cycle 4 busy=0, done=0, out=3'b000; no done pulse follows. A fresh start then completes normally.
6. Alternate configs:
   - WIDTH=1, DIGIT=1, all four input pairs, unsigned → 100, 001, 010, 010, each done at cycle 2.
   - WIDTH=8, DIGIT=8, signed, 8'hFF vs 8'h01 → 3'b100 at cycle 2.

Source files
------------

// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks two WIDTH-bit operands MSB-first, DIGIT bits
// per clock, stopping at the first differing chunk. Result is a 3-bit one-hot code.
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [2:0]       out
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NCHUNK - 1);
  localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CMP  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [2:0] CODE_NONE = 3'b000;
  localparam logic [2:0] CODE_LT   = 3'b100;
  localparam logic [2:0] CODE_EQ   = 3'b010;
  localparam logic [2:0] CODE_GT   = 3'b001;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("seq_mag_comparator: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  function automatic logic [2:0] chunk_code(input logic [DIGIT-1:0] a,
                                            input logic [DIGIT-1:0] b);
    if (a < b)      return CODE_LT;
    else if (a > b) return CODE_GT;
    else            return CODE_EQ;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             sgn_q,   sgn_d;
  logic [2:0]       res_q,   res_d;

  logic [WIDTH-1:0] a_shl, b_shl;
  logic [DIGIT-1:0] a_chunk, b_chunk;
  logic             flip_msb;
  logic [2:0]       cmp_code;

  // Operands shift left after each equal chunk so the live chunk is always the top DIGIT bits.
  generate
    if (NCHUNK > 1) begin : g_shift
      assign a_shl = {a_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
      assign b_shl = {b_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
    end else begin : g_noshift
      assign a_shl = '0;
      assign b_shl = '0;
    end
  endgenerate

  // Offset-binary trick: flipping both sign bits on the top chunk makes an unsigned compare signed.
  assign flip_msb = sgn_q && (idx_q == IDX_TOP);
  assign a_chunk  = a_q[WIDTH-1 -: DIGIT] ^ (flip_msb ? MSB_MASK : '0);
  assign b_chunk  = b_q[WIDTH-1 -: DIGIT] ^ (flip_msb ? MSB_MASK : '0);
  assign cmp_code = chunk_code(a_chunk, b_chunk);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          sgn_d   = signed_mode;
          idx_d   = IDX_TOP;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (cmp_code != CODE_EQ) begin
          res_d   = cmp_code;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          res_d   = CODE_EQ;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
          a_d   = a_shl;
          b_d   = b_shl;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      res_q   <= CODE_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign out  = res_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator: a vector table for the main function plus
// hand-written sequences for ignored starts, reset mid-compare and output holding.
module tb_seq_mag_comparator;

  logic clk = 1'b0;
  logic rst;

  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [2:0]  out16;

  logic        start1, sm1, busy1, done1;
  logic [0:0]  a1, b1;
  logic [2:0]  out1;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [2:0]  out8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] prev_out [3];

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .in1(a16), .in2(b16),
    .signed_mode(sm16), .busy(busy16), .done(done16), .out(out16));

  seq_mag_comparator #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .in1(a1), .in2(b1),
    .signed_mode(sm1), .busy(busy1), .done(done1), .out(out1));

  seq_mag_comparator #(.WIDTH(8), .DIGIT(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .in1(a8), .in2(b8),
    .signed_mode(sm8), .busy(busy8), .done(done8), .out(out8));

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int inst, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, input logic st);
    case (inst)
      0: begin a16 = a; b16 = b; sm16 = sm; start16 = st; end
      1: begin a1 = a[0:0]; b1 = b[0:0]; sm1 = sm; start1 = st; end
      default: begin a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; start8 = st; end
    endcase
  endtask

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy16 : (inst == 1) ? busy1 : busy8;
  endfunction
  function automatic logic get_done(input int inst);
    return (inst == 0) ? done16 : (inst == 1) ? done1 : done8;
  endfunction
  function automatic logic [2:0] get_out(input int inst);
    return (inst == 0) ? out16 : (inst == 1) ? out1 : out8;
  endfunction

  // Entered at the negedge of cycle 0 with the DUT idle; returns at the next cycle 0.
  task automatic run_vec(input vec_t v);
    drive(v.inst, v.a, v.b, v.sm, 1'b1);
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      if (c == 1) drive(v.inst, ~v.a, ~v.b, ~v.sm, 1'b0);
      check({v.name, " busy"}, 32'(get_busy(v.inst)), 32'd1);
      check({v.name, " done"}, 32'(get_done(v.inst)), 32'(c == v.lat));
      if (c == v.lat) check({v.name, " out"}, 32'(get_out(v.inst)), 32'(v.exp));
      else            check({v.name, " out hold"}, 32'(get_out(v.inst)), 32'(prev_out[v.inst]));
    end
    prev_out[v.inst] = v.exp;
    @(negedge clk);
    check({v.name, " idle busy"}, 32'(get_busy(v.inst)), 32'd0);
    check({v.name, " idle done"}, 32'(get_done(v.inst)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 16'h1234, 16'h1235, 1'b0, 3'b100, 5, "u lowchunk"};
    vecs[1]  = '{0, 16'h8000, 16'h7FFF, 1'b0, 3'b001, 2, "u 8000>7fff"};
    vecs[2]  = '{0, 16'h8000, 16'h7FFF, 1'b1, 3'b100, 2, "s 8000<7fff"};
    vecs[3]  = '{0, 16'hABCD, 16'hABCD, 1'b1, 3'b010, 5, "s equal"};
    vecs[4]  = '{0, 16'h0000, 16'h0010, 1'b0, 3'b100, 4, "u chunk1"};
    vecs[5]  = '{0, 16'hFFFF, 16'h0000, 1'b1, 3'b100, 2, "s -1<0"};
    vecs[6]  = '{0, 16'hFFFF, 16'hFFFE, 1'b1, 3'b001, 5, "s -1>-2"};
    vecs[7]  = '{0, 16'h7FFF, 16'h8000, 1'b1, 3'b001, 2, "s max>min"};
    vecs[8]  = '{0, 16'h1000, 16'h0FFF, 1'b0, 3'b001, 2, "u 1000>0fff"};
    vecs[9]  = '{1, 16'h0000, 16'h0001, 1'b0, 3'b100, 2, "w1 0<1"};
    vecs[10] = '{1, 16'h0001, 16'h0000, 1'b0, 3'b001, 2, "w1 1>0"};
    vecs[11] = '{1, 16'h0000, 16'h0000, 1'b0, 3'b010, 2, "w1 0=0"};
    vecs[12] = '{1, 16'h0001, 16'h0001, 1'b0, 3'b010, 2, "w1 1=1"};
    vecs[13] = '{1, 16'h0001, 16'h0000, 1'b1, 3'b100, 2, "w1 s -1<0"};
    vecs[14] = '{2, 16'h00FF, 16'h0001, 1'b1, 3'b100, 2, "w8 s ff<01"};
    vecs[15] = '{2, 16'h00FF, 16'h0001, 1'b0, 3'b001, 2, "w8 u ff>01"};

    for (int i = 0; i < 3; i++) begin
      prev_out[i] = 3'b000;
      drive(i, 16'h0, 16'h0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset busy", 32'(get_busy(i)), 32'd0);
      check("reset done", 32'(get_done(i)), 32'd0);
      check("reset out",  32'(get_out(i)),  32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Equal-operand result must persist through idle cycles.
    run_vec('{0, 16'hABCD, 16'hABCD, 1'b0, 3'b010, 5, "u equal"});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("equal hold", 32'(out16), 32'(3'b010));
    end

    // Start while busy is ignored; the next start after done is taken.
    drive(0, 16'h0001, 16'h0002, 1'b0, 1'b1);
    @(negedge clk); drive(0, 16'h0001, 16'h0002, 1'b0, 1'b0);
    @(negedge clk); drive(0, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    @(negedge clk); drive(0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    check("ignore c3 busy", 32'(busy16), 32'd1);
    @(negedge clk);
    check("ignore c4 done", 32'(done16), 32'd0);
    @(negedge clk);
    check("ignore c5 done", 32'(done16), 32'd1);
    check("ignore c5 out",  32'(out16),  32'(3'b100));
    @(negedge clk);
    check("ignore c6 busy", 32'(busy16), 32'd0);
    drive(0, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    @(negedge clk); drive(0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("restart c7 busy", 32'(busy16), 32'd1);
    check("restart c7 done", 32'(done16), 32'd0);
    @(negedge clk);
    check("restart c8 done", 32'(done16), 32'd1);
    check("restart c8 out",  32'(out16),  32'(3'b001));
    prev_out[0] = 3'b001;
    @(negedge clk);

    // Reset during a compare abandons it with no done pulse.
    drive(0, 16'h5A5A, 16'h5A5A, 1'b0, 1'b1);
    @(negedge clk); drive(0, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst busy", 32'(busy16), 32'd0);
    check("midrst done", 32'(done16), 32'd0);
    check("midrst out",  32'(out16),  32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst no done", 32'(done16), 32'd0);
    end
    for (int i = 0; i < 3; i++) prev_out[i] = 3'b000;
    run_vec('{0, 16'h1234, 16'h1235, 1'b0, 3'b100, 5, "post-rst"});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
